// File: rtl/sp_dma_pkg.sv
// Shared definitions for the SP memory-to-memory copy engine.
// The SRAM, CTL and the bench use these widths and constants.
package sp_dma_pkg;

   localparam int ADDR_W              = 16;
   localparam int DATA_W              = 32;
   localparam int LEN_W               = 16;
   localparam int DMA_CYCLES_PER_WORD = 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } dma_state_e;

endpackage

// File: rtl/sp_dma_if.sv
// Single-port SRAM access port shared between sp_dma (master) and CTL (slave).
interface sp_dma_if;
   import sp_dma_pkg::*;

   logic              dma_req;
   logic              dma_gnt;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_di;
   logic              dma_en;
   logic              dma_we;
   logic [DATA_W-1:0] sram_do;

   modport master (
      output dma_req, dma_addr, dma_di, dma_en, dma_we,
      input  dma_gnt, sram_do
   );

   modport slave (
      input  dma_req, dma_addr, dma_di, dma_en, dma_we,
      output dma_gnt, sram_do
   );

endinterface

// File: rtl/sp_dma.sv
// Ascending word-copy engine: read one word, capture it, write it, repeat,
// using the shared SRAM port only in cycles CTL grants it.
//
// state   | meaning
// IDLE    | waiting for start
// RD      | requesting port to read word at src_ptr
// CAP     | port released; read data captured into buffer
// WR      | requesting port to write buffer to dst_ptr
// DONE    | one-cycle completion pulse
module sp_dma
   import sp_dma_pkg::*;
#(
   parameter int ADDR_W = sp_dma_pkg::ADDR_W,
   parameter int DATA_W = sp_dma_pkg::DATA_W,
   parameter int LEN_W  = sp_dma_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [LEN_W-1:0]  len,
   sp_dma_if.master          sram,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remaining
);

   dma_state_e        state, state_nxt;
   logic [ADDR_W-1:0] src_ptr, src_nxt;
   logic [ADDR_W-1:0] dst_ptr, dst_nxt;
   logic [LEN_W-1:0]  rem_nxt;
   logic [DATA_W-1:0] buffer;

   always_comb begin
      state_nxt = state;
      src_nxt   = src_ptr;
      dst_nxt   = dst_ptr;
      rem_nxt   = remaining;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  src_nxt   = src;
                  dst_nxt   = dst;
                  rem_nxt   = len;
                  state_nxt = ST_RD;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_RD: begin
            if (sram.dma_gnt) state_nxt = ST_CAP;
         end
         ST_CAP: state_nxt = ST_WR;
         ST_WR: begin
            if (sram.dma_gnt) begin
               rem_nxt   = remaining - LEN_W'(1);
               src_nxt   = src_ptr + ADDR_W'(1);
               dst_nxt   = dst_ptr + ADDR_W'(1);
               state_nxt = (remaining == LEN_W'(1)) ? ST_DONE : ST_RD;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered outputs are loaded from next-state values so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         src_ptr       <= '0;
         dst_ptr       <= '0;
         remaining     <= '0;
         buffer        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         sram.dma_req  <= 1'b0;
         sram.dma_addr <= '0;
      end else begin
         state         <= state_nxt;
         src_ptr       <= src_nxt;
         dst_ptr       <= dst_nxt;
         remaining     <= rem_nxt;
         busy          <= (state_nxt != ST_IDLE);
         done          <= (state_nxt == ST_DONE);
         sram.dma_req  <= (state_nxt == ST_RD) || (state_nxt == ST_WR);
         sram.dma_addr <= (state_nxt == ST_WR) ? dst_nxt : src_nxt;
         if (state == ST_CAP) buffer <= sram.sram_do;
      end
   end

   assign sram.dma_di = buffer;

   // Reset gating makes an abort take effect in the reset cycle itself,
   // so no write lands while the engine is being cleared.
   assign sram.dma_en = sram.dma_req & sram.dma_gnt & reset;
   assign sram.dma_we = (state == ST_WR) & sram.dma_req & sram.dma_gnt & reset;

endmodule

// File: tb/tb_sp_dma.sv
// Scoreboard bench for sp_dma: stimulus pushes expected SRAM reads/writes and
// done times; a negedge monitor pops and compares as the DUT presents them.
module tb_sp_dma;
   import sp_dma_pkg::*;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src = '0, dst = '0, len = '0;
   logic        busy, done;
   logic [15:0] remaining;
   int          cyc = 0;
   int          t0 = 0;
   int          checks = 0;
   int          failures = 0;

   logic [31:0] mem   [0:65535];
   logic [31:0] model [0:65535];

   wr_t         wq[$];
   logic [15:0] rq[$];
   int          dq[$];

   sp_dma_if bus();

   sp_dma dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .sram      (bus),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.dma_en) begin
         if (bus.dma_we) mem[bus.dma_addr] = bus.dma_di;
         else            bus.sram_do <= mem[bus.dma_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [31:0] d);
      mem[a]   = d;
      model[a] = d;
   endtask

   // Sequential ascending copy model; nrd/nwr limit how far the DUT is
   // expected to get, done_lat < 0 means no done pulse is expected.
   task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           input int nrd, input int nwr, input int done_lat);
      @(posedge clk); #1;
      src = s; dst = d; len = l; start = 1'b1;
      t0 = cyc;
      for (int i = 0; i < nrd; i++) rq.push_back(s + 16'(i));
      for (int i = 0; i < nwr; i++) begin
         logic [15:0] ra, wa;
         ra = s + 16'(i);
         wa = d + 16'(i);
         model[wa] = model[ra];
         wq.push_back({wa, model[ra]});
      end
      if (done_lat >= 0) dq.push_back(t0 + done_lat);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic busy_window(input int total, input string name);
      for (int n = 1; n <= total + 1; n++) begin
         @(negedge clk);
         chk(name, busy, (n <= total) ? 1'b1 : 1'b0);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((wq.size() != 0 || rq.size() != 0 || dq.size() != 0 || busy) && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk(name, (n < 300) ? 1'b1 : 1'b0, 1'b1);
      repeat (2) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (!bus.dma_gnt) begin
            chk("en_gated", bus.dma_en, 1'b0);
            chk("we_gated", bus.dma_we, 1'b0);
         end
         if (bus.dma_en && bus.dma_we) begin
            if (wq.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
            else begin
               wr_t e;
               e = wq.pop_front();
               chk("write_addr", bus.dma_addr, e.a);
               chk("write_data", bus.dma_di, e.d);
            end
         end else if (bus.dma_en) begin
            if (rq.size() == 0) chk("unexpected_read", 1'b1, 1'b0);
            else begin
               logic [15:0] ea;
               ea = rq.pop_front();
               chk("read_addr", bus.dma_addr, ea);
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
            else begin
               int ec;
               ec = dq.pop_front();
               chk("done_cycle", cyc, ec);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]   = '0;
         model[i] = '0;
      end
      bus.dma_gnt = 1'b1;
      bus.sram_do = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_req", bus.dma_req, 1'b0);
      chk("rst_addr", bus.dma_addr, 32'h0);
      chk("rst_di", bus.dma_di, 32'h0);
      chk("rst_remaining", remaining, 32'h0);
      reset = 1'b1;

      // basic copy, continuous grant
      for (int i = 0; i < 4; i++) poke(16'd100 + 16'(i), 32'hA0 + 32'(i));
      do_start(16'd100, 16'd200, 16'd4, 4, 4, 13);
      busy_window(13, "basic_busy");
      wait_drain("basic_drain");
      for (int i = 0; i < 4; i++) chk("basic_mem", mem[16'd200 + 16'(i)], 32'hA0 + 32'(i));
      chk("basic_remaining", remaining, 32'h0);

      // zero length
      do_start(16'd5, 16'd6, 16'd0, 0, 0, 1);
      busy_window(1, "len0_busy");
      wait_drain("len0_drain");

      // grant starvation: 5 denied cycles in RD, 3 in WR
      poke(16'd700, 32'h11);
      poke(16'd701, 32'h22);
      bus.dma_gnt = 1'b0;
      do_start(16'd700, 16'd800, 16'd2, 2, 2, 15);
      fork
         busy_window(15, "starve_busy");
         begin
            repeat (5) @(posedge clk); #1 bus.dma_gnt = 1'b1;
            repeat (2) @(posedge clk); #1 bus.dma_gnt = 1'b0;
            repeat (3) @(posedge clk); #1 bus.dma_gnt = 1'b1;
         end
      join
      wait_drain("starve_drain");
      chk("starve_mem0", mem[800], 32'h11);
      chk("starve_mem1", mem[801], 32'h22);

      // address wrap
      poke(16'hFFFE, 32'hDEAD0001);
      poke(16'hFFFF, 32'hDEAD0002);
      poke(16'h0000, 32'hDEAD0003);
      do_start(16'hFFFE, 16'h0010, 16'd3, 3, 3, 10);
      wait_drain("wrap_drain");
      chk("wrap_mem0", mem[16'h10], 32'hDEAD0001);
      chk("wrap_mem1", mem[16'h11], 32'hDEAD0002);
      chk("wrap_mem2", mem[16'h12], 32'hDEAD0003);

      // overlapping ranges replicate the first word
      for (int i = 0; i < 4; i++) poke(16'd50 + 16'(i), 32'(i + 1));
      do_start(16'd50, 16'd51, 16'd3, 3, 3, 10);
      wait_drain("overlap_drain");
      for (int i = 0; i < 4; i++) chk("overlap_mem", mem[16'd50 + 16'(i)], 32'h1);

      // reset during WR of word 2 (cycle 9)
      for (int i = 0; i < 5; i++) begin
         poke(16'd300 + 16'(i), 32'hB0 + 32'(i));
         poke(16'd400 + 16'(i), 32'h5A5A5A5A);
      end
      do_start(16'd300, 16'd400, 16'd5, 3, 2, -1);
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_req", bus.dma_req, 1'b0);
      chk("abort_en", bus.dma_en, 1'b0);
      chk("abort_addr", bus.dma_addr, 32'h0);
      chk("abort_di", bus.dma_di, 32'h0);
      chk("abort_remaining", remaining, 32'h0);
      wait_drain("abort_drain");
      chk("abort_mem0", mem[400], 32'hB0);
      chk("abort_mem1", mem[401], 32'hB1);
      chk("abort_mem2", mem[402], 32'h5A5A5A5A);
      chk("abort_mem4", mem[404], 32'h5A5A5A5A);

      // start while busy and in DONE cycle are ignored
      poke(16'd600, 32'hC0);
      poke(16'd601, 32'hC1);
      do_start(16'd600, 16'd650, 16'd2, 2, 2, 7);
      repeat (2) @(posedge clk);
      #1;
      src = 16'd0; dst = 16'd600; len = 16'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("done_start_ignored", busy, 1'b0);
      wait_drain("ignore_drain");
      chk("ignore_mem0", mem[650], 32'hC0);
      chk("ignore_mem1", mem[651], 32'hC1);
      chk("ignore_src_intact", mem[600], 32'hC0);
      chk("ignore_remaining", remaining, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
